// File: rtl/sr_latch_sequencer.sv
// Round-robin sequencer that shares a bank of NOR SR latches between requesters,
// driving one timed set/reset pulse at a time and checking the latch afterwards.
module sr_latch_sequencer #(
   parameter  int NREQ      = 4,
   parameter  int NFLAG     = 8,
   parameter  int IDXW      = 3,
   parameter  int PULSE_CYC = 2,
   parameter  int GAP_CYC   = 1,
   localparam int IDW       = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NREQ-1:0]      req_valid,
   input  logic [NREQ-1:0]      req_op,
   input  logic [NREQ*IDXW-1:0] req_idx,
   output logic [NREQ-1:0]      req_ready,
   output logic [NFLAG-1:0]     latch_set,
   output logic [NFLAG-1:0]     latch_reset,
   input  logic [NFLAG-1:0]     flag_q,
   output logic                 busy,
   output logic                 done_valid,
   output logic [IDW-1:0]       done_id,
   output logic                 done_ok
);

   localparam int CMAX = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
   localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

   typedef enum logic [1:0] {IDLE, PULSE, GAP, CHECK} state_t;

   state_t           state, state_n;
   logic [CW-1:0]    cnt, cnt_n;
   logic             op_r, op_n;
   logic [IDXW-1:0]  idx_r, idx_n;
   logic [IDW-1:0]   id_r, id_n;
   logic [IDW-1:0]   rr_ptr, rr_n;
   logic             found;
   logic [IDW-1:0]   win;
   logic             q_sel, q_hit;
   logic [NFLAG-1:0] hit_n;
   logic [NFLAG-1:0] set_d, reset_d;
   logic             busy_d, dv_d, ok_d;
   logic [IDW-1:0]   did_d;

   // Round-robin search: first pass from rr_ptr upward, second pass wraps to 0
   always_comb begin
      found = 1'b0;
      win   = '0;
      for (int j = 0; j < NREQ; j++) begin
         if (!found && req_valid[j] && (IDW'(j) >= rr_ptr)) begin
            found = 1'b1;
            win   = IDW'(j);
         end
      end
      for (int j = 0; j < NREQ; j++) begin
         if (!found && req_valid[j]) begin
            found = 1'b1;
            win   = IDW'(j);
         end
      end
   end

   // Gated by rst_n so no grant leaks out while reset is held
   always_comb begin
      req_ready = '0;
      if (rst_n && (state == IDLE) && found) req_ready[win] = 1'b1;
   end

   // Out-of-range indices leave q_hit low, which forces done_ok to 0
   always_comb begin
      q_hit = 1'b0;
      q_sel = 1'b0;
      for (int i = 0; i < NFLAG; i++) begin
         if (idx_r == IDXW'(i)) begin
            q_hit = 1'b1;
            q_sel = flag_q[i];
         end
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      op_n    = op_r;
      idx_n   = idx_r;
      id_n    = id_r;
      rr_n    = rr_ptr;
      ok_d    = 1'b0;
      case (state)
         IDLE: begin
            if (found) begin
               state_n = PULSE;
               cnt_n   = CW'(PULSE_CYC - 1);
               op_n    = req_op[win];
               idx_n   = req_idx[int'(win)*IDXW +: IDXW];
               id_n    = win;
               rr_n    = (win == IDW'(NREQ - 1)) ? '0 : win + 1'b1;
            end
         end
         PULSE: begin
            if (cnt == '0) begin
               state_n = GAP;
               cnt_n   = CW'(GAP_CYC - 1);
            end else begin
               cnt_n = cnt - 1'b1;
            end
         end
         GAP: begin
            if (cnt == '0) begin
               state_n = CHECK;
               ok_d    = q_hit && (q_sel == op_r);
            end else begin
               cnt_n = cnt - 1'b1;
            end
         end
         CHECK:   state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // Outputs are decoded from the next state so they can be registered without lag
   always_comb begin
      for (int i = 0; i < NFLAG; i++) hit_n[i] = (idx_n == IDXW'(i));
      set_d   = ((state_n == PULSE) &&  op_n) ? hit_n : '0;
      reset_d = ((state_n == PULSE) && !op_n) ? hit_n : '0;
      busy_d  = (state_n != IDLE);
      dv_d    = (state_n == CHECK);
      did_d   = (state_n == CHECK) ? id_r : '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         cnt         <= '0;
         op_r        <= 1'b0;
         idx_r       <= '0;
         id_r        <= '0;
         rr_ptr      <= '0;
         latch_set   <= '0;
         latch_reset <= '0;
         busy        <= 1'b0;
         done_valid  <= 1'b0;
         done_id     <= '0;
         done_ok     <= 1'b0;
      end else begin
         state       <= state_n;
         cnt         <= cnt_n;
         op_r        <= op_n;
         idx_r       <= idx_n;
         id_r        <= id_n;
         rr_ptr      <= rr_n;
         latch_set   <= set_d;
         latch_reset <= reset_d;
         busy        <= busy_d;
         done_valid  <= dv_d;
         done_id     <= did_d;
         done_ok     <= ok_d;
      end
   end

endmodule
